// File: rtl/bf16_to_fp8_drain.sv
// Write-back drain: requantizes BF16 accumulator results to FP8 E4M3 (bias 7) and packs
// LANES bytes per word onto a valid/ready output stream with sticky exception flags.
module bf16_to_fp8_drain #(
   parameter int LANES    = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [15:0]        in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic [LANES-1:0]   out_keep,
   output logic               out_last,
   output logic               flag_ovf,
   output logic               flag_unf,
   output logic               flag_nan
);

   localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;

   logic                s;
   logic [7:0]          e;
   logic [6:0]          m;
   logic [7:0]          sig;
   logic [10:0]         sub_ext;
   logic [6:0]          mag;
   logic [6:0]          mag_rnd;
   logic                guard;
   logic                sticky;
   logic                rnd;
   logic [7:0]          ovf_byte;
   logic [7:0]          fp8;
   logic                ovf_c;
   logic                unf_c;
   logic                nan_c;

   logic [LCW-1:0]      lane_cnt;
   logic [8*LANES-1:0]  pack_q;
   logic [8*LANES-1:0]  pack_nxt;
   logic [LANES-1:0]    keep_nxt;
   logic                accept;
   logic                word_done;

   assign s        = in_data[15];
   assign e        = in_data[14:7];
   assign m        = in_data[6:0];
   assign sig      = {1'b1, m};
   assign ovf_byte = SATURATE ? {s, 7'h77} : {s, 7'h78};

   // Subnormal range e=117..120 shifts the significand right by 8..5; bits [7:0] hold guard/sticky.
   assign sub_ext  = 11'({sig, 8'h00} >> (8'd125 - e));

   always_comb begin
      fp8     = 8'h00;
      ovf_c   = 1'b0;
      nan_c   = 1'b0;
      mag     = 7'h00;
      mag_rnd = 7'h00;
      guard   = 1'b0;
      sticky  = 1'b0;
      rnd     = 1'b0;
      if (e == 8'hFF) begin
         if (m != 7'h00) begin
            fp8   = 8'h7F;
            nan_c = 1'b1;
         end else begin
            fp8 = {s, 7'h78};
         end
      end else if (e == 8'h00) begin
         fp8 = {s, 7'h00};
      end else if (e > 8'd134) begin
         fp8   = ovf_byte;
         ovf_c = 1'b1;
      end else if (e >= 8'd117) begin
         if (e >= 8'd121) begin
            // exponent rebias e-120 taken modulo 16, valid because e is 121..134 here
            mag    = {e[3:0] + 4'd8, m[6:4]};
            guard  = m[3];
            sticky = |m[2:0];
         end else begin
            mag    = {4'b0000, sub_ext[10:8]};
            guard  = sub_ext[7];
            sticky = |sub_ext[6:0];
         end
         rnd     = guard && (sticky || mag[0]);
         mag_rnd = mag + {6'b000000, rnd};
         if (mag_rnd[6:3] == 4'hF) begin
            fp8   = ovf_byte;
            ovf_c = 1'b1;
         end else begin
            fp8 = {s, mag_rnd};
         end
      end else begin
         fp8 = {s, 7'h00};
      end
      unf_c = (e != 8'hFF) && ((e != 8'h00) || (m != 7'h00)) && (fp8[6:0] == 7'h00);
   end

   assign in_ready  = rst_n && !clear && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign word_done = (lane_cnt == LCW'(LANES - 1)) || in_last;

   always_comb begin
      pack_nxt = pack_q;
      pack_nxt[8*lane_cnt +: 8] = fp8;
      keep_nxt = '0;
      for (int i = 0; i < LANES; i++) begin
         keep_nxt[i] = (i <= int'(lane_cnt));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt  <= '0;
         pack_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         flag_ovf  <= 1'b0;
         flag_unf  <= 1'b0;
         flag_nan  <= 1'b0;
      end else begin
         if (clear) begin
            lane_cnt <= '0;
            pack_q   <= '0;
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
            flag_nan <= 1'b0;
         end else if (accept) begin
            flag_ovf <= flag_ovf | ovf_c;
            flag_unf <= flag_unf | unf_c;
            flag_nan <= flag_nan | nan_c;
            if (word_done) begin
               lane_cnt <= '0;
               pack_q   <= '0;
            end else begin
               lane_cnt <= lane_cnt + 1'b1;
               pack_q   <= pack_nxt;
            end
         end
         // A word loading in the same cycle as a handshake keeps out_valid high.
         if (accept && word_done) begin
            out_valid <= 1'b1;
            out_data  <= pack_nxt;
            out_keep  <= keep_nxt;
            out_last  <= in_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bf16_to_fp8_drain.sv
// Scoreboard bench for bf16_to_fp8_drain: a saturating and an Inf-overflow instance run in
// lockstep on directed vectors; monitors pop expected words on every output handshake.
module tb_bf16_to_fp8_drain;

   localparam int LANES = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready_s, out_valid_s, out_last_s, ovf_s, unf_s, nan_s;
   logic [31:0] out_data_s;
   logic [3:0]  out_keep_s;
   logic        in_ready_i, out_valid_i, out_last_i, ovf_i, unf_i, nan_i;
   logic [31:0] out_data_i;
   logic [3:0]  out_keep_i;

   word_t       q_s[$];
   word_t       q_i[$];
   word_t       ws, wi;
   logic [31:0] mb_s, mb_i;
   logic [3:0]  mkeep;
   int          mlane;
   int          tests_run = 0;
   int          tests_failed = 0;

   always #5 clk = ~clk;

   bf16_to_fp8_drain #(.LANES(LANES), .SATURATE(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_keep(out_keep_s), .out_last(out_last_s),
      .flag_ovf(ovf_s), .flag_unf(unf_s), .flag_nan(nan_s)
   );

   bf16_to_fp8_drain #(.LANES(LANES), .SATURATE(1'b0)) u_dut_inf (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready_i), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_i), .out_ready(out_ready), .out_data(out_data_i),
      .out_keep(out_keep_i), .out_last(out_last_i),
      .flag_ovf(ovf_i), .flag_unf(unf_i), .flag_nan(nan_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mlane = 0;
      mb_s  = 32'h0;
      mb_i  = 32'h0;
      mkeep = 4'h0;
   endtask

   task automatic send(input logic [15:0] d, input logic [7:0] es, input logic [7:0] ei,
                       input logic last);
      int    waited;
      word_t w;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready_s && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready_s) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: in_ready stuck low for 0x%0h, expected high", d);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      mb_s[8*mlane +: 8] = es;
      mb_i[8*mlane +: 8] = ei;
      mkeep[mlane] = 1'b1;
      if (mlane == LANES-1 || last) begin
         w.data = mb_s; w.keep = mkeep; w.last = last;
         q_s.push_back(w);
         w.data = mb_i;
         q_i.push_back(w);
         model_reset();
      end else begin
         mlane++;
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      model_reset();
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1;
      out_ready = v;
   endtask

   task automatic check_flags(input string tag, input logic ovf, input logic unf, input logic nan);
      chk({tag, "_ovf_sat"}, {31'b0, ovf_s}, {31'b0, ovf});
      chk({tag, "_unf_sat"}, {31'b0, unf_s}, {31'b0, unf});
      chk({tag, "_nan_sat"}, {31'b0, nan_s}, {31'b0, nan});
      chk({tag, "_ovf_inf"}, {31'b0, ovf_i}, {31'b0, ovf});
      chk({tag, "_unf_inf"}, {31'b0, unf_i}, {31'b0, unf});
      chk({tag, "_nan_inf"}, {31'b0, nan_i}, {31'b0, nan});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  {30'b0, in_ready_s, in_ready_i},   32'h0);
      chk({tag, "_out_valid"}, {30'b0, out_valid_s, out_valid_i}, 32'h0);
      chk({tag, "_out_data"},  out_data_s | out_data_i,           32'h0);
      chk({tag, "_out_keep"},  {28'b0, out_keep_s | out_keep_i},  32'h0);
      chk({tag, "_out_last"},  {30'b0, out_last_s, out_last_i},   32'h0);
      check_flags(tag, 1'b0, 1'b0, 1'b0);
   endtask

   // Output monitors: compare every handshaken word against the queued expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid_s && out_ready) begin
         if (q_s.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sat_unexpected_word: got 0x%0h, expected no word", out_data_s);
         end else begin
            ws = q_s.pop_front();
            chk("sat_data", out_data_s, ws.data);
            chk("sat_keep", {28'b0, out_keep_s}, {28'b0, ws.keep});
            chk("sat_last", {31'b0, out_last_s}, {31'b0, ws.last});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid_i && out_ready) begin
         if (q_i.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL inf_unexpected_word: got 0x%0h, expected no word", out_data_i);
         end else begin
            wi = q_i.pop_front();
            chk("inf_data", out_data_i, wi.data);
            chk("inf_keep", {28'b0, out_keep_i}, {28'b0, wi.keep});
            chk("inf_last", {31'b0, out_last_i}, {31'b0, wi.last});
         end
      end
   end

   initial begin
      int n;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {30'b0, in_ready_s, in_ready_i}, 32'h3);

      // Basic packing and one-cycle latency
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      send(16'h4000, 8'h40, 8'h40, 1'b0);
      send(16'hBF80, 8'hB8, 8'hB8, 1'b0);
      chk("t1_valid_before", {31'b0, out_valid_s}, 32'h0);
      send(16'h0000, 8'h00, 8'h00, 1'b0);
      chk("t1_valid_after", {31'b0, out_valid_s}, 32'h1);
      chk("t1_data_direct", out_data_s, 32'h00B84038);

      // Round to nearest even
      send(16'h3F88, 8'h38, 8'h38, 1'b0);
      send(16'h3F98, 8'h3A, 8'h3A, 1'b0);
      send(16'h3F89, 8'h39, 8'h39, 1'b1);
      check_flags("t2", 1'b0, 1'b0, 1'b0);

      // Overflow under both policies
      send(16'h4377, 8'h77, 8'h77, 1'b0);
      check_flags("t3_max", 1'b0, 1'b0, 1'b0);
      send(16'h4378, 8'h77, 8'h78, 1'b0);
      check_flags("t3_ovf", 1'b1, 1'b0, 1'b0);
      send(16'hC380, 8'hF7, 8'hF8, 1'b0);
      send(16'h4377, 8'h77, 8'h77, 1'b0);
      do_clear();
      check_flags("t3_clear", 1'b0, 1'b0, 1'b0);
      send(16'hFF80, 8'hF8, 8'hF8, 1'b1);
      check_flags("t3_inf", 1'b0, 1'b0, 1'b0);

      // Subnormals, underflow and NaN
      send(16'h3C00, 8'h04, 8'h04, 1'b0);
      send(16'h3A81, 8'h01, 8'h01, 1'b0);
      check_flags("t4_sub", 1'b0, 1'b0, 1'b0);
      send(16'h3A80, 8'h00, 8'h00, 1'b0);
      check_flags("t4_unf", 1'b0, 1'b1, 1'b0);
      send(16'h3C7F, 8'h08, 8'h08, 1'b0);
      do_clear();
      send(16'h0001, 8'h00, 8'h00, 1'b0);
      check_flags("t4_flush", 1'b0, 1'b1, 1'b0);
      send(16'h7FC1, 8'h7F, 8'h7F, 1'b1);
      check_flags("t4_nan", 1'b0, 1'b1, 1'b1);

      // Partial word on in_last, then a fresh word from lane 0
      do_clear();
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      send(16'h4000, 8'h40, 8'h40, 1'b1);
      send(16'h4000, 8'h40, 8'h40, 1'b0);
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      send(16'h0000, 8'h00, 8'h00, 1'b0);
      send(16'hBF80, 8'hB8, 8'hB8, 1'b0);

      // Backpressure: pending word holds for 10 cycles and survives clear
      set_ready(1'b0);
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      send(16'h4000, 8'h40, 8'h40, 1'b0);
      send(16'hBF80, 8'hB8, 8'hB8, 1'b0);
      send(16'h3F88, 8'h38, 8'h38, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("stall_in_ready", {31'b0, in_ready_s}, 32'h0);
         chk("stall_valid", {31'b0, out_valid_s}, 32'h1);
         chk("stall_data", out_data_s, 32'h38B84038);
      end
      do_clear();
      chk("stall_clear_valid", {31'b0, out_valid_s}, 32'h1);
      chk("stall_clear_data", out_data_s, 32'h38B84038);
      chk("stall_clear_keep", {28'b0, out_keep_s}, 32'hF);
      set_ready(1'b1);

      // Clear drops partially packed bytes
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      send(16'h4000, 8'h40, 8'h40, 1'b0);
      do_clear();
      send(16'hBF80, 8'hB8, 8'hB8, 1'b0);
      send(16'h4000, 8'h40, 8'h40, 1'b1);

      // Reset during a stalled word clears everything asynchronously
      set_ready(1'b0);
      send(16'h4378, 8'h77, 8'h78, 1'b0);
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      send(16'h3F80, 8'h38, 8'h38, 1'b0);
      chk("pre_reset_ovf", {31'b0, ovf_s}, 32'h1);
      chk("pre_reset_valid", {31'b0, out_valid_s}, 32'h1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset_stall");
      q_s.delete();
      q_i.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_ready(1'b1);

      // Reset mid-word discards the buffered byte
      send(16'h4000, 8'h40, 8'h40, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset_mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send(16'h3F80, 8'h38, 8'h38, 1'b1);

      n = 0;
      while ((q_s.size() != 0 || q_i.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("queue_drain", q_s.size() + q_i.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
